// File: rtl/wb_stage_pkg.sv
// Shared definitions for the Wishbone stage pipe: FSM state encoding,
// default parameter values and the response-resolution helper.
package wb_stage_pkg;

  localparam int DEF_DW  = 32;
  localparam int DEF_AW  = 32;
  localparam int DEF_TW  = 4;
  localparam int DEF_TOW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  // A slave reporting ack and err together is treated as an error.
  function automatic logic resolve_ack(input logic ack, input logic err);
    return ack & ~err;
  endfunction

endpackage

// File: rtl/wb_stage_tmo.sv
// Ack-wait timer: cleared by load, counts while enabled (saturating), and
// flags expiry in the cycle where the count reaches limit-1.
module wb_stage_tmo
  import wb_stage_pkg::*;
#(
  parameter int TOW = DEF_TOW
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           i_load,
  input  logic           i_enable,
  input  logic [TOW-1:0] i_limit,
  output logic           o_expire
);

  logic [TOW-1:0] r_count;
  logic           w_at_limit;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i || i_load) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + TOW'(1);
    end
  end

  // A zero limit disables expiry entirely.
  assign w_at_limit = (i_limit != '0) && (r_count == (i_limit - TOW'(1)));
  assign o_expire   = i_enable && w_at_limit;

endmodule

// File: rtl/wb_stage_pipe.sv
// Single-outstanding Wishbone pipeline stage: registers a tid-matched request
// toward the slave, returns the registered response, with abort and timeout.
module wb_stage_pipe
  import wb_stage_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int AW  = DEF_AW,
  parameter int TW  = DEF_TW,
  parameter int TOW = DEF_TOW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [TW-1:0]   cfg_slave_id,
  input  logic            cfg_bypass,
  input  logic [TOW-1:0]  cfg_timeout,
  input  logic [DW-1:0]   m_wbd_dat_i,
  input  logic [AW-1:0]   m_wbd_adr_i,
  input  logic [DW/8-1:0] m_wbd_sel_i,
  input  logic            m_wbd_we_i,
  input  logic            m_wbd_cyc_i,
  input  logic            m_wbd_stb_i,
  input  logic [TW-1:0]   m_wbd_tid_i,
  output logic [DW-1:0]   m_wbd_dat_o,
  output logic            m_wbd_ack_o,
  output logic            m_wbd_err_o,
  input  logic [DW-1:0]   s_wbd_dat_i,
  input  logic            s_wbd_ack_i,
  input  logic            s_wbd_err_i,
  output logic [DW-1:0]   s_wbd_dat_o,
  output logic [AW-1:0]   s_wbd_adr_o,
  output logic [DW/8-1:0] s_wbd_sel_o,
  output logic            s_wbd_we_o,
  output logic            s_wbd_cyc_o,
  output logic            s_wbd_stb_o,
  output logic [TW-1:0]   s_wbd_tid_o,
  output logic            timeout_o,
  input  logic            timeout_clr_i
);

  typedef struct packed {
    logic [DW-1:0]   dat;
    logic [AW-1:0]   adr;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic [TW-1:0]   tid;
  } stage_req_t;

  wb_state_e  r_state;
  stage_req_t r_s_req;
  logic [DW-1:0] r_m_dat;
  logic          r_m_ack;
  logic          r_m_err;
  logic          r_timeout;

  logic w_tid_match;
  logic w_start;
  logic w_s_resp;
  logic w_tmo_load;
  logic w_tmo_en;
  logic w_expire;
  logic w_tmo_set;

  assign w_tid_match = (m_wbd_tid_i == cfg_slave_id);
  assign w_start     = m_wbd_stb_i && m_wbd_cyc_i && w_tid_match;
  assign w_s_resp    = s_wbd_ack_i || s_wbd_err_i;

  // The timer is frozen while bypassed and restarts from zero on BUSY entry.
  assign w_tmo_load = !cfg_bypass && (r_state == ST_IDLE) && w_start;
  assign w_tmo_en   = !cfg_bypass && (r_state == ST_BUSY);

  wb_stage_tmo #(
    .TOW (TOW)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_load   (w_tmo_load),
    .i_enable (w_tmo_en),
    .i_limit  (cfg_timeout),
    .o_expire (w_expire)
  );

  // Timeout fires only if the master is still in the cycle and the slave is silent.
  assign w_tmo_set = w_tmo_en && m_wbd_cyc_i && !w_s_resp && w_expire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_s_req <= '0;
      r_m_dat <= '0;
      r_m_ack <= 1'b0;
      r_m_err <= 1'b0;
    end else if (cfg_bypass) begin
      r_state <= ST_IDLE;
      r_s_req <= '0;
      r_m_ack <= 1'b0;
      r_m_err <= 1'b0;
    end else begin
      r_m_ack <= 1'b0;
      r_m_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_s_req.dat <= m_wbd_dat_i;
            r_s_req.adr <= m_wbd_adr_i;
            r_s_req.sel <= m_wbd_sel_i;
            r_s_req.we  <= m_wbd_we_i;
            r_s_req.tid <= m_wbd_tid_i;
            r_s_req.cyc <= 1'b1;
            r_s_req.stb <= 1'b1;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Abort outranks any slave response arriving in the same cycle.
          if (!m_wbd_cyc_i) begin
            r_s_req <= '0;
            r_state <= ST_IDLE;
          end else if (w_s_resp) begin
            r_m_dat <= s_wbd_dat_i;
            r_m_ack <= resolve_ack(s_wbd_ack_i, s_wbd_err_i);
            r_m_err <= s_wbd_err_i;
            r_s_req <= '0;
            r_state <= ST_RESP;
          end else if (w_expire) begin
            r_m_dat <= '0;
            r_m_err <= 1'b1;
            r_s_req <= '0;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flag: a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timeout <= 1'b0;
    end else if (w_tmo_set) begin
      r_timeout <= 1'b1;
    end else if (timeout_clr_i) begin
      r_timeout <= 1'b0;
    end
  end

  assign timeout_o = r_timeout;

  assign s_wbd_dat_o = cfg_bypass ? m_wbd_dat_i : r_s_req.dat;
  assign s_wbd_adr_o = cfg_bypass ? m_wbd_adr_i : r_s_req.adr;
  assign s_wbd_sel_o = cfg_bypass ? m_wbd_sel_i : r_s_req.sel;
  assign s_wbd_we_o  = cfg_bypass ? m_wbd_we_i  : r_s_req.we;
  assign s_wbd_tid_o = cfg_bypass ? m_wbd_tid_i : r_s_req.tid;
  assign s_wbd_cyc_o = cfg_bypass ? (m_wbd_cyc_i && w_tid_match) : r_s_req.cyc;
  assign s_wbd_stb_o = cfg_bypass ? (m_wbd_stb_i && w_tid_match) : r_s_req.stb;

  assign m_wbd_dat_o = cfg_bypass ? s_wbd_dat_i : r_m_dat;
  assign m_wbd_ack_o = cfg_bypass ? (w_tid_match && resolve_ack(s_wbd_ack_i, s_wbd_err_i))
                                  : r_m_ack;
  assign m_wbd_err_o = cfg_bypass ? (w_tid_match && s_wbd_err_i) : r_m_err;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Scoreboard bench for wb_stage_pipe: stimulus predicts each response into a
// queue, a negedge monitor pops and compares whenever the DUT responds.
module tb_wb_stage_pipe;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TW  = 4;
  localparam int TOW = 8;
  localparam int BUDGET = 300;

  typedef struct {
    logic          ack;
    logic          err;
    logic [DW-1:0] dat;
  } resp_t;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [TW-1:0]   cfg_slave_id;
  logic            cfg_bypass;
  logic [TOW-1:0]  cfg_timeout;
  logic [DW-1:0]   m_wbd_dat_i;
  logic [AW-1:0]   m_wbd_adr_i;
  logic [DW/8-1:0] m_wbd_sel_i;
  logic            m_wbd_we_i;
  logic            m_wbd_cyc_i;
  logic            m_wbd_stb_i;
  logic [TW-1:0]   m_wbd_tid_i;
  logic [DW-1:0]   m_wbd_dat_o;
  logic            m_wbd_ack_o;
  logic            m_wbd_err_o;
  logic [DW-1:0]   s_wbd_dat_i;
  logic            s_wbd_ack_i;
  logic            s_wbd_err_i;
  logic [DW-1:0]   s_wbd_dat_o;
  logic [AW-1:0]   s_wbd_adr_o;
  logic [DW/8-1:0] s_wbd_sel_o;
  logic            s_wbd_we_o;
  logic            s_wbd_cyc_o;
  logic            s_wbd_stb_o;
  logic [TW-1:0]   s_wbd_tid_o;
  logic            timeout_o;
  logic            timeout_clr_i;

  int    checks   = 0;
  int    failures = 0;
  resp_t exp_q[$];

  wb_stage_pipe #(.DW(DW), .AW(AW), .TW(TW), .TOW(TOW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cfg_slave_id  (cfg_slave_id),
    .cfg_bypass    (cfg_bypass),
    .cfg_timeout   (cfg_timeout),
    .m_wbd_dat_i   (m_wbd_dat_i),
    .m_wbd_adr_i   (m_wbd_adr_i),
    .m_wbd_sel_i   (m_wbd_sel_i),
    .m_wbd_we_i    (m_wbd_we_i),
    .m_wbd_cyc_i   (m_wbd_cyc_i),
    .m_wbd_stb_i   (m_wbd_stb_i),
    .m_wbd_tid_i   (m_wbd_tid_i),
    .m_wbd_dat_o   (m_wbd_dat_o),
    .m_wbd_ack_o   (m_wbd_ack_o),
    .m_wbd_err_o   (m_wbd_err_o),
    .s_wbd_dat_i   (s_wbd_dat_i),
    .s_wbd_ack_i   (s_wbd_ack_i),
    .s_wbd_err_i   (s_wbd_err_i),
    .s_wbd_dat_o   (s_wbd_dat_o),
    .s_wbd_adr_o   (s_wbd_adr_o),
    .s_wbd_sel_o   (s_wbd_sel_o),
    .s_wbd_we_o    (s_wbd_we_o),
    .s_wbd_cyc_o   (s_wbd_cyc_o),
    .s_wbd_stb_o   (s_wbd_stb_o),
    .s_wbd_tid_o   (s_wbd_tid_o),
    .timeout_o     (timeout_o),
    .timeout_clr_i (timeout_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented response must match the oldest prediction.
  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk_i);
      if (m_wbd_ack_o === 1'b1 || m_wbd_err_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp actual=ack%0b/err%0b required=none t=%0t",
                   m_wbd_ack_o, m_wbd_err_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_ack", 64'(m_wbd_ack_o), 64'(e.ack));
          check("resp_err", 64'(m_wbd_err_o), 64'(e.err));
          check("resp_dat", 64'(m_wbd_dat_o), 64'(e.dat));
        end
      end
    end
  end

  task automatic master_idle();
    m_wbd_cyc_i = 1'b0;
    m_wbd_stb_i = 1'b0;
    m_wbd_we_i  = 1'b0;
    m_wbd_tid_i = '0;
  endtask

  // Reference outcome: the slave wins if it answers within the first
  // cfg_timeout BUSY cycles, otherwise the timer answers with an error.
  task automatic predict(input int delay, input bit sack, input bit serr, input int tmo,
                         input logic [DW-1:0] sdat, output int idx, output resp_t r);
    if (delay >= 0 && (tmo == 0 || delay < tmo)) begin
      idx   = delay;
      r.ack = sack && !serr;
      r.err = serr;
      r.dat = sdat;
    end else begin
      idx   = tmo - 1;
      r.ack = 1'b0;
      r.err = 1'b1;
      r.dat = '0;
    end
  endtask

  // delay<0 means a silent slave. Returns in the response cycle.
  task automatic run_txn(input bit skip_wait, input logic [TW-1:0] tid, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [DW/8-1:0] sel, input logic [DW-1:0] sdat,
                         input int delay, input bit sack, input bit serr);
    int    exp_idx;
    int    k;
    bit    done;
    resp_t r;
    if (!skip_wait) begin
      @(posedge clk_i); #1;
    end
    m_wbd_tid_i = tid;
    m_wbd_we_i  = we;
    m_wbd_adr_i = adr;
    m_wbd_dat_i = dat;
    m_wbd_sel_i = sel;
    m_wbd_cyc_i = 1'b1;
    m_wbd_stb_i = 1'b1;
    if (tid != cfg_slave_id) begin
      for (int i = 0; i < 6; i++) begin
        @(posedge clk_i); #1;
        check("nomatch_s_stb", 64'(s_wbd_stb_o), 64'(0));
      end
      master_idle();
      return;
    end
    predict(delay, sack, serr, int'(cfg_timeout), sdat, exp_idx, r);
    exp_q.push_back(r);
    @(posedge clk_i); #1;
    check("req_s_stb", 64'(s_wbd_stb_o), 64'(1));
    check("req_s_cyc", 64'(s_wbd_cyc_o), 64'(1));
    check("req_s_adr", 64'(s_wbd_adr_o), 64'(adr));
    check("req_s_dat", 64'(s_wbd_dat_o), 64'(dat));
    check("req_s_we",  64'(s_wbd_we_o),  64'(we));
    check("req_s_sel", 64'(s_wbd_sel_o), 64'(sel));
    check("req_s_tid", 64'(s_wbd_tid_o), 64'(tid));
    done = 1'b0;
    k    = 0;
    while (!done && k < BUDGET) begin
      if (k == delay) begin
        s_wbd_ack_i = sack;
        s_wbd_err_i = serr;
        s_wbd_dat_i = sdat;
      end else begin
        s_wbd_dat_i = $urandom;
      end
      @(posedge clk_i); #1;
      s_wbd_ack_i = 1'b0;
      s_wbd_err_i = 1'b0;
      if (m_wbd_ack_o || m_wbd_err_o) done = 1'b1;
      else k++;
    end
    check("resp_latency", 64'(k), 64'(exp_idx));
    check("resp_s_stb_clr", 64'(s_wbd_stb_o), 64'(0));
    check("resp_s_cyc_clr", 64'(s_wbd_cyc_o), 64'(0));
    master_idle();
  endtask

  task automatic abort_txn(input int abort_idx);
    @(posedge clk_i); #1;
    m_wbd_tid_i = cfg_slave_id;
    m_wbd_adr_i = 32'h300;
    m_wbd_cyc_i = 1'b1;
    m_wbd_stb_i = 1'b1;
    @(posedge clk_i); #1;
    check("abort_s_stb", 64'(s_wbd_stb_o), 64'(1));
    repeat (abort_idx) begin
      @(posedge clk_i); #1;
    end
    master_idle();
    s_wbd_ack_i = 1'b1;
    s_wbd_dat_i = 32'hBAD0BAD0;
    @(posedge clk_i); #1;
    s_wbd_ack_i = 1'b0;
    check("abort_s_stb_clr", 64'(s_wbd_stb_o), 64'(0));
    check("abort_s_cyc_clr", 64'(s_wbd_cyc_o), 64'(0));
    check("abort_no_ack", 64'(m_wbd_ack_o), 64'(0));
    // Stage must be back in IDLE: a new request is taken straight away.
    run_txn(1'b1, cfg_slave_id, 1'b0, 32'h304, 32'h0, 4'hF, 32'hA5A5A5A5, 1, 1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_bus"}, 64'({s_wbd_stb_o, s_wbd_cyc_o, s_wbd_we_o, s_wbd_tid_o, s_wbd_sel_o}),
          64'(0));
    check({tag, "_s_adr"}, 64'(s_wbd_adr_o), 64'(0));
    check({tag, "_s_dat"}, 64'(s_wbd_dat_o), 64'(0));
    check({tag, "_m_resp"}, 64'({m_wbd_ack_o, m_wbd_err_o, timeout_o}), 64'(0));
    check({tag, "_m_dat"}, 64'(m_wbd_dat_o), 64'(0));
  endtask

  initial begin : stimulus
    int   tmo_opts[4] = '{0, 3, 5, 8};
    int   delay;
    logic [TW-1:0] tid;
    rst_i         = 1'b1;
    cfg_slave_id  = 4'd3;
    cfg_bypass    = 1'b0;
    cfg_timeout   = '0;
    timeout_clr_i = 1'b0;
    m_wbd_dat_i   = '0;
    m_wbd_adr_i   = '0;
    m_wbd_sel_i   = '0;
    s_wbd_dat_i   = '0;
    s_wbd_ack_i   = 1'b0;
    s_wbd_err_i   = 1'b0;
    master_idle();
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_i = 1'b0;

    // Write with a slave acking two cycles after s_stb.
    run_txn(1'b0, 4'd3, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 2, 1'b1, 1'b0);
    @(posedge clk_i); #1;
    check("after_write_idle", 64'({s_wbd_stb_o, m_wbd_ack_o, m_wbd_err_o}), 64'(0));

    // Read where ack and err arrive together, then an immediate back-to-back read.
    run_txn(1'b0, 4'd3, 1'b0, 32'h200, 32'h0, 4'hF, 32'h12345678, 0, 1'b1, 1'b1);
    run_txn(1'b0, 4'd3, 1'b0, 32'h204, 32'h0, 4'h3, 32'h0BADF00D, 0, 1'b1, 1'b0);

    // Timeout of 5 with a silent slave; flag sticks until cleared.
    cfg_timeout = 8'd5;
    run_txn(1'b0, 4'd3, 1'b0, 32'h400, 32'h0, 4'hF, 32'h0, -1, 1'b0, 1'b0);
    check("tmo_flag_set", 64'(timeout_o), 64'(1));
    repeat (3) begin
      @(posedge clk_i); #1;
    end
    check("tmo_flag_sticky", 64'(timeout_o), 64'(1));
    timeout_clr_i = 1'b1;
    @(posedge clk_i); #1;
    timeout_clr_i = 1'b0;
    check("tmo_flag_clr", 64'(timeout_o), 64'(0));

    // Slave answers on the last allowed cycle: response wins over the timer.
    cfg_timeout = 8'd3;
    run_txn(1'b0, 4'd3, 1'b0, 32'h408, 32'h0, 4'hF, 32'h55AA55AA, 2, 1'b1, 1'b0);
    check("tmo_edge_no_flag", 64'(timeout_o), 64'(0));

    // Set and clear in the same cycle: set wins, clear applies next cycle.
    timeout_clr_i = 1'b1;
    run_txn(1'b0, 4'd3, 1'b1, 32'h40C, 32'h1, 4'hF, 32'h0, -1, 1'b0, 1'b0);
    check("tmo_set_wins", 64'(timeout_o), 64'(1));
    @(posedge clk_i); #1;
    check("tmo_clr_after", 64'(timeout_o), 64'(0));
    timeout_clr_i = 1'b0;

    // Shortest timeout.
    cfg_timeout = 8'd1;
    run_txn(1'b0, 4'd3, 1'b0, 32'h410, 32'h0, 4'hF, 32'h0, -1, 1'b0, 1'b0);
    timeout_clr_i = 1'b1;
    @(posedge clk_i); #1;
    timeout_clr_i = 1'b0;
    cfg_timeout = 8'd0;

    // Foreign tid is ignored.
    run_txn(1'b0, 4'd2, 1'b1, 32'h500, 32'h1234, 4'hF, 32'h0, 0, 1'b1, 1'b0);

    // Abort two cycles into BUSY with a coincident slave ack.
    abort_txn(2);

    // Reset during BUSY, followed by a late slave ack.
    @(posedge clk_i); #1;
    m_wbd_tid_i = 4'd3;
    m_wbd_adr_i = 32'h600;
    m_wbd_cyc_i = 1'b1;
    m_wbd_stb_i = 1'b1;
    @(posedge clk_i); #1;
    check("rstbusy_s_stb", 64'(s_wbd_stb_o), 64'(1));
    rst_i = 1'b1;
    master_idle();
    @(posedge clk_i); #1;
    rst_i       = 1'b0;
    s_wbd_ack_i = 1'b1;
    s_wbd_dat_i = 32'hFEEDFACE;
    check_all_zero("rst_busy");
    @(posedge clk_i); #1;
    s_wbd_ack_i = 1'b0;
    check_all_zero("rst_late_ack");

    // Bypass: combinational path gated by the tid match.
    @(posedge clk_i); #1;
    cfg_bypass  = 1'b1;
    m_wbd_tid_i = 4'd3;
    m_wbd_adr_i = 32'h700;
    m_wbd_dat_i = 32'hC0FFEE00;
    m_wbd_cyc_i = 1'b1;
    m_wbd_stb_i = 1'b1;
    exp_q.push_back('{ack: 1'b1, err: 1'b0, dat: 32'h13572468});
    s_wbd_ack_i = 1'b1;
    s_wbd_dat_i = 32'h13572468;
    #1;
    check("byp_s_stb", 64'(s_wbd_stb_o), 64'(1));
    check("byp_s_adr", 64'(s_wbd_adr_o), 64'(32'h700));
    check("byp_s_dat", 64'(s_wbd_dat_o), 64'(32'hC0FFEE00));
    @(posedge clk_i); #1;
    s_wbd_ack_i = 1'b0;
    m_wbd_tid_i = 4'd9;
    #1;
    check("byp_nomatch_stb", 64'({s_wbd_stb_o, s_wbd_cyc_o}), 64'(0));
    master_idle();
    @(posedge clk_i); #1;
    cfg_bypass = 1'b0;

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      cfg_timeout = TOW'(tmo_opts[$urandom_range(0, 3)]);
      tid   = ($urandom_range(0, 3) == 0) ? TW'($urandom_range(0, 15)) : 4'd3;
      delay = $urandom_range(0, 6);
      if (cfg_timeout != 0 && $urandom_range(0, 4) == 0) delay = -1;
      run_txn(1'b0, tid, 1'($urandom), $urandom, $urandom, 4'($urandom), $urandom,
              delay, 1'b1, ($urandom_range(0, 3) == 0));
      timeout_clr_i = 1'b1;
      @(posedge clk_i); #1;
      timeout_clr_i = 1'b0;
    end

    repeat (4) @(posedge clk_i);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
